// File: rtl/scene_flasher.sv
// scene_flasher: parses framed scene uploads from the UART byte stream and
// writes each assembled object word into the scene memory's flash port.
// Frame: SYNC_BYTE, count N, then N objects of OBJ_BYTES bytes (MSB first).
// Optional build macro SCENE_FLASHER_CHECKSUM_EN adds a trailing XOR byte
// (over N and every object byte) that must match before the frame commits.
module scene_flasher #(
  parameter int         OBJ_WIDTH        = 20,
  parameter int         IDX_WIDTH        = 8,
  parameter int         MAX_OBJS         = 16,
  parameter int         DEFAULT_NUM_OBJS = 1,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter int         TIMEOUT_CYCLES   = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           rx_byte,
  output logic                 flash_obj_wen,
  output logic [IDX_WIDTH-1:0] flash_obj_idx,
  output logic [OBJ_WIDTH-1:0] flash_obj_data,
  output logic [IDX_WIDTH-1:0] num_objs,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int OBJ_BYTES = (OBJ_WIDTH + 7) / 8;
  localparam int SR_W      = OBJ_BYTES * 8;
  localparam int BC_W      = $clog2(OBJ_BYTES + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BC_W-1:0]      LAST_BYTE = BC_W'(OBJ_BYTES - 1);
  localparam logic [TO_W-1:0]      TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_WIDTH-1:0] ONE_IDX   = IDX_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    COMMIT
`ifdef SCENE_FLASHER_CHECKSUM_EN
    , CHECK
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] n_q, n_d;
  logic [IDX_WIDTH-1:0] obj_cnt_q, obj_cnt_d;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 wen_q, wen_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [OBJ_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0] num_objs_q, num_objs_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 timeout;
`ifdef SCENE_FLASHER_CHECKSUM_EN
  logic [7:0]           ck_q, ck_d;
`endif

  // Idle-gap counter: cleared by every byte and while idle, saturating
  // otherwise; the abort fires on the cycle it reaches TIMEOUT_CYCLES.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q != IDLE && !byte_valid) begin
      to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + TO_W'(1);
      timeout  = (to_cnt_d == TO_LIMIT) && (state_q != COMMIT);
    end
  end

  // Frame parser: next state, object assembly and the registered outputs.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    obj_cnt_d  = obj_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    wen_d      = 1'b0;
    idx_d      = idx_q;
    data_d     = data_q;
    num_objs_d = num_objs_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef SCENE_FLASHER_CHECKSUM_EN
    ck_d       = ck_q;
`endif
    if (timeout) begin
      // Slots already written stay; only the committed count is protected.
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_valid && rx_byte == SYNC_BYTE) state_d = COUNT;
        end
        COMMIT: begin
          num_objs_d = n_q;
          done_d     = 1'b1;
          // A byte landing here is treated exactly as in IDLE.
          state_d    = (byte_valid && rx_byte == SYNC_BYTE) ? COUNT : IDLE;
        end
        COUNT: begin
          if (byte_valid) begin
            if (rx_byte == 8'd0 || 32'(rx_byte) > MAX_OBJS) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              n_d        = IDX_WIDTH'(rx_byte);
              obj_cnt_d  = '0;
              byte_cnt_d = '0;
              state_d    = DATA;
`ifdef SCENE_FLASHER_CHECKSUM_EN
              ck_d       = rx_byte;
`endif
            end
          end
        end
        DATA: begin
          if (byte_valid) begin
            // Truncating the concatenation keeps the newest OBJ_BYTES bytes.
            sr_d = SR_W'({sr_q, rx_byte});
`ifdef SCENE_FLASHER_CHECKSUM_EN
            ck_d = ck_q ^ rx_byte;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
              wen_d      = 1'b1;
              idx_d      = obj_cnt_q;
              data_d     = sr_d[OBJ_WIDTH-1:0];
              obj_cnt_d  = obj_cnt_q + ONE_IDX;
              byte_cnt_d = '0;
              if (obj_cnt_q + ONE_IDX == n_q) begin
`ifdef SCENE_FLASHER_CHECKSUM_EN
                state_d = CHECK;
`else
                state_d = COMMIT;
`endif
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end
        end
`ifdef SCENE_FLASHER_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            if (rx_byte == ck_q) begin
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      obj_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      to_cnt_q   <= '0;
      wen_q      <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      num_objs_q <= IDX_WIDTH'(DEFAULT_NUM_OBJS);
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SCENE_FLASHER_CHECKSUM_EN
      ck_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      obj_cnt_q  <= obj_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      to_cnt_q   <= to_cnt_d;
      wen_q      <= wen_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      num_objs_q <= num_objs_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef SCENE_FLASHER_CHECKSUM_EN
      ck_q       <= ck_d;
`endif
    end
  end

  assign flash_obj_wen  = wen_q;
  assign flash_obj_idx  = idx_q;
  assign flash_obj_data = data_q;
  assign num_objs       = num_objs_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = done_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_scene_flasher.sv
// tb_scene_flasher: drives directed and random byte streams into
// scene_flasher and compares every cycle against a byte-level frame model.
module tb_scene_flasher;

  localparam int         OBJ_WIDTH = 20;
  localparam int         IDX_WIDTH = 8;
  localparam int         MAX_OBJS  = 16;
  localparam int         DEF_OBJS  = 1;
  localparam int         TMO       = 50;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         OBJ_BYTES = (OBJ_WIDTH + 7) / 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 byte_valid = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 flash_obj_wen;
  logic [IDX_WIDTH-1:0] flash_obj_idx;
  logic [OBJ_WIDTH-1:0] flash_obj_data;
  logic [IDX_WIDTH-1:0] num_objs;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_err;

  scene_flasher #(
    .OBJ_WIDTH(OBJ_WIDTH), .IDX_WIDTH(IDX_WIDTH), .MAX_OBJS(MAX_OBJS),
    .DEFAULT_NUM_OBJS(DEF_OBJS), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .rx_byte(rx_byte),
    .flash_obj_wen(flash_obj_wen), .flash_obj_idx(flash_obj_idx),
    .flash_obj_data(flash_obj_data), .num_objs(num_objs), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: consumes whole bytes, tracks where it is in the frame.
  int         m_mode;   // 0 hunting for sync, 1 count, 2 payload, 3 checksum
  int         m_n, m_obj, m_idle;
  bit         m_commit; // frame finished; commit shows one cycle later
  logic [7:0] m_xor;
  logic [7:0] m_buf[$];

  logic                 e_wen, e_done, e_err, e_busy;
  logic [IDX_WIDTH-1:0] e_idx, e_num;
  logic [OBJ_WIDTH-1:0] e_data;

  // What the DUT was seen doing.
  int wen_seen = 0, done_seen = 0, err_seen = 0;
  int                   wr_idx_log[$];
  logic [OBJ_WIDTH-1:0] wr_data_log[$];

  logic [7:0] txq[$];

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_obj = 0; m_idle = 0; m_commit = 0; m_xor = 8'h00;
    m_buf.delete();
    e_wen = 0; e_done = 0; e_err = 0; e_busy = 0;
    e_idx = '0; e_data = '0; e_num = IDX_WIDTH'(DEF_OBJS);
  endtask

  task automatic model_update(input bit v, input logic [7:0] b);
    logic [31:0] word;
    e_wen = 0; e_done = 0; e_err = 0;
    if (m_commit) begin
      e_done = 1; e_num = IDX_WIDTH'(m_n); m_commit = 0;
    end
    if (v) begin
      m_idle = 0;
      case (m_mode)
        0: if (b == SYNC) m_mode = 1;
        1: begin
          if (b == 0 || int'(b) > MAX_OBJS) begin
            e_err = 1; m_mode = 0;
          end else begin
            m_n = int'(b); m_obj = 0; m_xor = b; m_buf.delete(); m_mode = 2;
          end
        end
        2: begin
          m_buf.push_back(b);
          m_xor = m_xor ^ b;
          if (m_buf.size() == OBJ_BYTES) begin
            word = 0;
            foreach (m_buf[i]) word = word * 256 + 32'(m_buf[i]);
            e_wen  = 1;
            e_idx  = IDX_WIDTH'(m_obj);
            e_data = OBJ_WIDTH'(word % (32'd1 << OBJ_WIDTH));
            m_obj++;
            m_buf.delete();
            if (m_obj == m_n) begin
`ifdef SCENE_FLASHER_CHECKSUM_EN
              m_mode = 3;
`else
              m_mode = 0; m_commit = 1;
`endif
            end
          end
        end
        default: begin
          if (b == m_xor) m_commit = 1;
          else e_err = 1;
          m_mode = 0;
        end
      endcase
    end else if (m_mode != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        e_err = 1; m_mode = 0;
      end
    end
    e_busy = (m_mode != 0) || m_commit;
  endtask

  // One clock cycle: compare this cycle's outputs with the model, then
  // drive the next input and advance the model by it.
  task automatic step(input bit r, input bit v, input logic [7:0] b);
    @(negedge clk);
    n_cmp++;
    if (flash_obj_wen !== e_wen) begin
      n_bad++; $display("FAIL wen @%0t: got %b want %b", $time, flash_obj_wen, e_wen);
    end
    if (e_wen) begin
      n_cmp++;
      if (flash_obj_idx !== e_idx || flash_obj_data !== e_data) begin
        n_bad++;
        $display("FAIL write @%0t: got idx %0d data %h want idx %0d data %h",
                 $time, flash_obj_idx, flash_obj_data, e_idx, e_data);
      end
    end
    n_cmp++;
    if (frame_done !== e_done) begin
      n_bad++; $display("FAIL frame_done @%0t: got %b want %b", $time, frame_done, e_done);
    end
    n_cmp++;
    if (frame_err !== e_err) begin
      n_bad++; $display("FAIL frame_err @%0t: got %b want %b", $time, frame_err, e_err);
    end
    n_cmp++;
    if (num_objs !== e_num) begin
      n_bad++; $display("FAIL num_objs @%0t: got %0d want %0d", $time, num_objs, e_num);
    end
    n_cmp++;
    if (busy !== e_busy) begin
      n_bad++; $display("FAIL busy @%0t: got %b want %b", $time, busy, e_busy);
    end
    if (flash_obj_wen === 1'b1) begin
      wen_seen++;
      wr_idx_log.push_back(int'(flash_obj_idx));
      wr_data_log.push_back(flash_obj_data);
    end
    if (frame_done === 1'b1) done_seen++;
    if (frame_err === 1'b1) err_seen++;
    rst = r; byte_valid = v; rx_byte = b;
    if (r) model_reset();
    else model_update(v, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00);
  endtask

  // Send txq with 0..max_gap idle cycles after each byte.
  task automatic send_txq(input int max_gap);
    foreach (txq[i]) begin
      step(0, 1, txq[i]);
      idle($urandom_range(0, max_gap));
    end
  endtask

  // Appends the trailing XOR byte when the checksum build is active.
  task automatic append_ck(input bit good);
`ifdef SCENE_FLASHER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < txq.size(); i++) x = x ^ txq[i];
    txq.push_back(good ? x : ~x);
`else
    if (!good) txq.push_back(8'h00);
`endif
  endtask

  task automatic test_reset();
    rst = 1; byte_valid = 0; rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 0;
    model_update(0, 8'h00);
    n_cmp++;
    if (flash_obj_wen !== 1'b0 || busy !== 1'b0 || num_objs !== IDX_WIDTH'(1) ||
        frame_done !== 1'b0 || frame_err !== 1'b0 || flash_obj_idx !== '0 ||
        flash_obj_data !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got wen %b busy %b num %0d done %b err %b idx %0d data %h",
               flash_obj_wen, busy, num_objs, frame_done, frame_err, flash_obj_idx,
               flash_obj_data);
    end
    idle(10);
    n_cmp++;
    if (wen_seen != 0 || done_seen != 0 || err_seen != 0) begin
      n_bad++;
      $display("FAIL reset_idle: got wen %0d done %0d err %0d want 0 0 0",
               wen_seen, done_seen, err_seen);
    end
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = wen_seen; d0 = done_seen;
    txq = '{8'hA5, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
    append_ck(1);
    send_txq(0);
    idle(4);
    n_cmp++;
    if (wen_seen - w0 != 2 || wr_idx_log[w0] != 0 || wr_data_log[w0] !== 20'hABCDE ||
        wr_idx_log[w0+1] != 1 || wr_data_log[w0+1] !== 20'h12345) begin
      n_bad++;
      $display("FAIL basic_writes: got %0d writes want 2 (idx0=ABCDE idx1=12345)",
               wen_seen - w0);
    end
    n_cmp++;
    if (done_seen - d0 != 1 || num_objs !== IDX_WIDTH'(2)) begin
      n_bad++;
      $display("FAIL basic_commit: got done %0d num %0d want 1 2", done_seen - d0, num_objs);
    end
  endtask

  task automatic test_bad_count();
    int w0, e0;
    w0 = wen_seen; e0 = err_seen;
    txq = '{8'h33, 8'hA5, 8'h00};
    send_txq(0);
    idle(3);
    txq = '{8'hA5, 8'h11};
    send_txq(1);
    idle(3);
    n_cmp++;
    if (err_seen - e0 != 2 || wen_seen != w0 || num_objs !== IDX_WIDTH'(2) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_count: got err %0d writes %0d num %0d busy %b want 2 0 2 0",
               err_seen - e0, wen_seen - w0, num_objs, busy);
    end
  endtask

  task automatic test_timeout();
    int w0, e0;
    w0 = wen_seen; e0 = err_seen;
    txq = '{8'hA5, 8'h02};
    repeat (3) txq.push_back(8'($urandom_range(0, 255)));
    send_txq(0);
    idle(TMO + 10);
    n_cmp++;
    if (wen_seen - w0 != 1 || err_seen - e0 != 1 || num_objs !== IDX_WIDTH'(2)) begin
      n_bad++;
      $display("FAIL timeout: got writes %0d err %0d num %0d want 1 1 2",
               wen_seen - w0, err_seen - e0, num_objs);
    end
  endtask

  task automatic test_reset_midframe();
    int w0;
    txq = '{8'hA5, 8'h02, 8'h11};
    send_txq(0);
    w0 = wen_seen;
    step(1, 1, 8'h22);
    step(0, 0, 8'h00);
    n_cmp++;
    if (busy !== 1'b0 || num_objs !== IDX_WIDTH'(DEF_OBJS) || wen_seen != w0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy %b num %0d writes %0d want 0 1 0",
               busy, num_objs, wen_seen - w0);
    end
    txq = '{8'hA5, 8'h01, 8'h07, 8'h65, 8'h43};
    append_ck(1);
    send_txq(1);
    idle(3);
    n_cmp++;
    if (num_objs !== IDX_WIDTH'(1) || wen_seen - w0 != 1 || wr_idx_log[w0] != 0 ||
        wr_data_log[w0] !== 20'h76543) begin
      n_bad++;
      $display("FAIL reset_refill: got num %0d writes %0d want 1 1 at idx 0",
               num_objs, wen_seen - w0);
    end
  endtask

  task automatic test_bad_checksum();
`ifdef SCENE_FLASHER_CHECKSUM_EN
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    txq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    append_ck(0);
    send_txq(0);
    idle(3);
    n_cmp++;
    if (done_seen != d0 || err_seen - e0 != 1 || num_objs !== IDX_WIDTH'(1)) begin
      n_bad++;
      $display("FAIL bad_checksum: got done %0d err %0d num %0d want 0 1 1",
               done_seen - d0, err_seen - e0, num_objs);
    end
`endif
  endtask

  // Two frames with no gap: the second SYNC lands on the commit cycle.
  task automatic test_back_to_back();
    int d0;
    d0 = done_seen;
    txq = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5};
    append_ck(1);
    send_txq(0);
    txq = '{8'hA5, 8'h02, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    append_ck(1);
    send_txq(0);
    idle(3);
    n_cmp++;
    if (done_seen - d0 != 2 || num_objs !== IDX_WIDTH'(2)) begin
      n_bad++;
      $display("FAIL back_to_back: got done %0d num %0d want 2 2", done_seen - d0, num_objs);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] g;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h5A;
        step(0, 1, g);
      end
      n = $urandom_range(0, MAX_OBJS + 3);
      txq = '{SYNC, 8'(n)};
      if (n >= 1 && n <= MAX_OBJS) begin
        repeat (n * OBJ_BYTES) txq.push_back(8'($urandom_range(0, 255)));
        append_ck($urandom_range(0, 7) != 0);
      end
      send_txq($urandom_range(0, 2));
    end
    idle(TMO + 5);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bad_count();
    test_timeout();
    test_reset_midframe();
    test_bad_checksum();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
